img_fir_filter_n: RTL and testbench

Parametrised streaming 1-D FIR image filter and the next generation of the fixed single-channel i_x/o_y filter datapath. It takes NCH pixel channels per beat over a valid/ready handshake. Coefficients are programmable, with a configurable right-shift, rounding, saturation, start-of-line edge replication and a bypass mode. It sits between the pixel source and sink inside rtl_top, and its register port is driven by the top-level register decoder in the same clock domain.

---
 rtl/img_fir_filter_n.sv | 134 +++++++++++++
 tb/tb_img_fir_filter_n.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/img_fir_filter_n.sv
// img_fir_filter_n: streaming multi-channel FIR image filter with programmable taps
module img_fir_filter_n #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int TAPS   = 5,
  parameter int COEF_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [15:0]           cfg_wdata,
  output logic [15:0]           cfg_rdata,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  i_sol,
  input  logic [NCH*DATA_W-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [NCH*DATA_W-1:0] o_data
);
  localparam int AW  = DATA_W + 1 + COEF_W + $clog2(TAPS);
  localparam int MID = TAPS / 2;
  localparam logic signed [AW:0] MAXV = (AW+1)'((1 << DATA_W) - 1);

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic                     bypass_q, bypass_d;
  logic [3:0]               shift_q, shift_d;
  logic [DATA_W-1:0]        hist_q [NCH][TAPS];
  logic [DATA_W-1:0]        hist_d [NCH][TAPS];
  logic                     s1_valid_q, s1_valid_d;
  logic signed [AW-1:0]     s1_acc_q [NCH];
  logic signed [AW-1:0]     s1_acc_d [NCH];
  logic signed [AW-1:0]     sum [NCH];
  logic [NCH*DATA_W-1:0]    s1_pix_q, s1_pix_d;
  logic                     s1_bypass_q, s1_bypass_d;
  logic [3:0]               s1_shift_q, s1_shift_d;
  logic                     o_valid_q, o_valid_d;
  logic [NCH*DATA_W-1:0]    o_data_q, o_data_d;
  logic signed [AW:0]       rnd;
  logic signed [AW:0]       r [NCH];
  logic                     adv, take;
  logic                     unused_ok;

  assign unused_ok = ^cfg_wdata;
  assign i_ready   = adv;
  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;

  // register file: writes land next clock, reads are combinational
  always_comb begin
    coef_d    = coef_q;
    bypass_d  = bypass_q;
    shift_d   = shift_q;
    cfg_rdata = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (cfg_we && cfg_addr == 4'(i)) coef_d[i] = cfg_wdata[COEF_W-1:0];
      if (cfg_addr == 4'(i)) cfg_rdata = 16'(coef_q[i]);
    end
    if (cfg_addr == 4'(TAPS)) cfg_rdata = {8'h00, shift_q, 3'b000, bypass_q};
    if (cfg_we && cfg_addr == 4'(TAPS)) begin
      bypass_d = cfg_wdata[0];
      shift_d  = cfg_wdata[7:4];
    end
  end

  // history update, multiply-accumulate and S1 capture
  always_comb begin
    adv         = !o_valid_q || o_ready;
    take        = i_valid && adv;
    hist_d      = hist_q;
    s1_valid_d  = adv ? take : s1_valid_q;
    s1_pix_d    = adv ? i_data : s1_pix_q;
    s1_bypass_d = adv ? bypass_q : s1_bypass_q;
    s1_shift_d  = adv ? shift_q : s1_shift_q;
    for (int c = 0; c < NCH; c++) begin
      if (take) begin
        hist_d[c][0] = i_data[c*DATA_W +: DATA_W];
        for (int t = 1; t < TAPS; t++)
          hist_d[c][t] = i_sol ? i_data[c*DATA_W +: DATA_W] : hist_q[c][t-1];
      end
      sum[c] = '0;
      for (int t = 0; t < TAPS; t++)
        sum[c] = sum[c] + AW'(coef_q[t]) * $signed(AW'({1'b0, hist_d[c][t]}));
      s1_acc_d[c] = adv ? sum[c] : s1_acc_q[c];
    end
  end

  // rounding, saturation and S2 capture
  always_comb begin
    o_valid_d = adv ? s1_valid_q : o_valid_q;
    o_data_d  = o_data_q;
    rnd       = (s1_shift_q == 4'd0) ? '0 : ((AW+1)'(1) <<< (s1_shift_q - 4'd1));
    for (int c = 0; c < NCH; c++) begin
      r[c] = ($signed({s1_acc_q[c][AW-1], s1_acc_q[c]}) + rnd) >>> s1_shift_q;
      if (adv)
        o_data_d[c*DATA_W +: DATA_W] = s1_bypass_q ? s1_pix_q[c*DATA_W +: DATA_W] :
                                       (r[c] < 0) ? '0 :
                                       (r[c] > MAXV) ? {DATA_W{1'b1}} : r[c][DATA_W-1:0];
    end
  end

  // all state, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF_W'(i == MID);
      bypass_q <= 1'b0;
      shift_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < TAPS; t++) hist_q[c][t] <= '0;
        s1_acc_q[c] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_bypass_q <= 1'b0;
      s1_shift_q  <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
    end else begin
      coef_q      <= coef_d;
      bypass_q    <= bypass_d;
      shift_q     <= shift_d;
      hist_q      <= hist_d;
      s1_acc_q    <= s1_acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_bypass_q <= s1_bypass_d;
      s1_shift_q  <= s1_shift_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
    end
  end
endmodule

// File: tb/tb_img_fir_filter_n.sv
// tb_img_fir_filter_n: vector table plus scoreboard bench for img_fir_filter_n
module tb_img_fir_filter_n;
  logic        clk, rstn, cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata, cfg_rdata;
  logic        i_valid, i_ready, i_sol, o_valid, o_ready;
  logic [23:0] i_data, o_data;

  img_fir_filter_n dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .i_valid(i_valid),
    .i_ready(i_ready), .i_sol(i_sol), .i_data(i_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_data(o_data)
  );

  typedef struct { logic sol; logic [23:0] d; logic [23:0] e; } vec_t;
  typedef struct { logic [23:0] e; int cyc; } exp_t;

  vec_t        tv [22];
  exp_t        q [$];
  int          tests = 0, fails = 0, cyc = 0;
  logic        chk_lat = 1'b1, held = 1'b0;
  logic [23:0] held_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] pk(input int v);
    return {8'(v + 2), 8'(v + 1), 8'(v)};
  endfunction

  // output monitor: scoreboard pop, latency and stall checks
  always @(negedge clk) begin
    exp_t x;
    if (!rstn) held = 1'b0;
    else begin
      if (o_valid && !o_ready) begin
        tests++;
        if (i_ready !== 1'b0) begin fails++; $display("FAIL stall_iready: got %b want 0", i_ready); end
      end
      if (o_valid && held) begin
        tests++;
        if (o_data !== held_d) begin fails++; $display("FAIL hold: got %h want %h", o_data, held_d); end
      end
      held   = o_valid && !o_ready;
      held_d = o_data;
      if (o_valid && o_ready) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL unexpected_beat: got %h want none", o_data); end
        else begin
          x = q.pop_front();
          if (o_data !== x.e) begin fails++; $display("FAIL data: got %h want %h", o_data, x.e); end
          if (chk_lat) begin
            tests++;
            if (cyc - x.cyc != 2) begin fails++; $display("FAIL latency: got %0d want 2", cyc - x.cyc); end
          end
        end
      end
    end
  end

  task automatic send(input logic sol, input logic [23:0] d, input logic [23:0] e);
    int k = 0;
    @(negedge clk);
    i_valid = 1'b1; i_sol = sol; i_data = d;
    while (!i_ready && k < 100) begin @(negedge clk); k++; end
    if (!i_ready) begin tests++; fails++; $display("FAIL send_timeout: got i_ready 0 want 1"); end
    else q.push_back('{e, cyc});
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk);
    i_valid = 1'b0; i_sol = 1'b0;
    while (q.size() > 0 && k < 100) begin @(negedge clk); k++; end
    tests++;
    if (q.size() > 0) begin fails++; $display("FAIL drain: got %0d pending want 0", q.size()); q.delete(); end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic chk_rd(input logic [3:0] a, input logic [15:0] e, input string nm);
    cfg_addr = a;
    #1;
    tests++;
    if (cfg_rdata !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, cfg_rdata, e); end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(tv[i].sol, tv[i].d, tv[i].e);
    drain();
  endtask

  initial begin
    // identity after reset: group delay of two taps
    tv[0]  = '{1'b1, pk(10), pk(10)};
    tv[1]  = '{1'b0, pk(20), pk(10)};
    tv[2]  = '{1'b0, pk(30), pk(10)};
    tv[3]  = '{1'b0, pk(40), pk(20)};
    // c0=c1=4, shift 3: round half up
    tv[4]  = '{1'b1, pk(10), pk(10)};
    tv[5]  = '{1'b0, pk(11), pk(11)};
    tv[6]  = '{1'b0, pk(20), pk(16)};
    // c0=127: saturate high
    tv[7]  = '{1'b1, {8'd202, 8'd201, 8'd200}, {8'd255, 8'd255, 8'd255}};
    tv[8]  = '{1'b1, {8'd3, 8'd2, 8'd1}, {8'd255, 8'd254, 8'd127}};
    // c0=-1: saturate low
    tv[9]  = '{1'b1, {8'd5, 8'd5, 8'd5}, 24'h0};
    tv[10] = '{1'b0, {8'd0, 8'd0, 8'd255}, 24'h0};
    // c4=1: edge replication
    tv[11] = '{1'b1, pk(50), pk(50)};
    tv[12] = '{1'b0, pk(60), pk(50)};
    tv[13] = '{1'b0, pk(70), pk(50)};
    tv[14] = '{1'b1, pk(9), pk(9)};
    tv[15] = '{1'b0, pk(1), pk(9)};
    tv[16] = '{1'b0, pk(2), pk(9)};
    tv[17] = '{1'b0, pk(3), pk(9)};
    tv[18] = '{1'b0, pk(4), pk(9)};
    tv[19] = '{1'b0, pk(5), pk(1)};
    // bypass with zero coefficients
    tv[20] = '{1'b0, {8'd3, 8'd200, 8'd7}, {8'd3, 8'd200, 8'd7}};
    tv[21] = '{1'b0, {8'd4, 8'd201, 8'd8}, {8'd4, 8'd201, 8'd8}};

    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    i_valid = 1'b0; i_sol = 1'b0; i_data = '0; o_ready = 1'b1;
    #2;
    tests++;
    if (o_valid !== 1'b0 || o_data !== 24'h0) begin fails++; $display("FAIL reset_out: got %b/%h want 0/0", o_valid, o_data); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk_rd(4'd2, 16'h0001, "reset_c2");
    chk_rd(4'd0, 16'h0000, "reset_c0");
    chk_rd(4'd5, 16'h0000, "reset_ctrl");
    wr(4'd7, 16'hFFFF);
    chk_rd(4'd7, 16'h0000, "oob_read");
    chk_rd(4'd0, 16'h0000, "oob_nowrite");

    run(0, 3);
    wr(4'd0, 16'd4); wr(4'd1, 16'd4); wr(4'd2, 16'd0); wr(4'd5, 16'h0030);
    chk_rd(4'd5, 16'h0030, "ctrl_rd");
    run(4, 6);
    wr(4'd5, 16'h0000); wr(4'd0, 16'd127); wr(4'd1, 16'd0);
    run(7, 8);
    wr(4'd0, 16'h00FF);
    chk_rd(4'd0, 16'hFFFF, "neg_coef_rd");
    run(9, 10);
    wr(4'd0, 16'd0); wr(4'd4, 16'd1);
    run(11, 19);
    wr(4'd4, 16'd0); wr(4'd5, 16'h0001);
    run(20, 21);

    // reset mid-stream drops in-flight beats at once
    for (int k = 0; k < 4; k++) send(1'b0, {8'(k), 8'(k + 1), 8'(k + 2)}, {8'(k), 8'(k + 1), 8'(k + 2)});
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    tests++;
    if (o_valid !== 1'b0) begin fails++; $display("FAIL async_reset: got o_valid %b want 0", o_valid); end
    q.delete();
    i_valid = 1'b0;
    chk_rd(4'd5, 16'h0000, "ctrl_after_reset");
    chk_rd(4'd2, 16'h0001, "c2_after_reset");
    @(negedge clk);
    rstn = 1'b1;

    // backpressure on the identity filter
    chk_lat = 1'b0;
    fork
      for (int k = 1; k <= 20; k++)
        send(k == 1, {8'(k + 40), 8'(k + 20), 8'(k)},
             {8'((k > 3 ? k - 2 : 1) + 40), 8'((k > 3 ? k - 2 : 1) + 20), 8'(k > 3 ? k - 2 : 1)});
      begin
        repeat (8) @(posedge clk);
        #2 o_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 o_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
